fft_frame_loader: RTL
=====================

// Module: fft_frame_loader
// PURPOSE
//  Sequences the SPI sample buffer (512x8 dual-port RAM, sclk domain) into the FFT input memory.
//  Counts samples written by the SPI loader. Once a full frame is buffered and the FFT is ready,
//  it reads the frame out oldest-first and converts each sample to complex fixed point.
//  Writes land in FFT memory at bit-reversed addresses, then one fft_start pulse is issued.
//  Sits between the buffer read port and the FFT core; it is the sole owner of that read port.
// PARAMETERS
//  SPI_WIDTH  8   sample width from SPI / buffer data width
//  BIT_WIDTH  16  FFT real/imag component width (>= SPI_WIDTH)
//  N          9   log2 frame length; frame = 2**N samples = buffer depth
// PORTS
//  sclk        in   1            sole clock, rising edge
//  reset       in   1            synchronous, active-low
//  wr_pulse    in   1            1-cycle strobe: buffer write of one sample occurs this cycle
//  wr_addr     in   N            buffer address the next write will use (oldest sample when full)
//  fft_ready   in   1            FFT core idle, may accept a new frame
//  buf_en_rd   out  1            buffer read enable
//  buf_add_rd  out  N            buffer read address
//  buf_dout    in   SPI_WIDTH    buffer read data, valid 1 cycle after buf_en_rd/buf_add_rd
//  fft_we      out  1            FFT memory write enable
//  fft_addr    out  N            FFT memory write address (bit-reversed sample index)
//  fft_din     out  2*BIT_WIDTH  {real, imag}; imag always 0
//  fft_start   out  1            1-cycle pulse: frame fully written
//  busy        out  1            high outside IDLE
//  frame_drop  out  1            sticky: unread samples overwritten before capture
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE; all outputs 0; sample count=0; rd_idx=0; frame_drop=0.
//  Reset is honoured in every state. Mid-frame reset abandons the frame; no fft_start is issued.
//  cnt: N+1 bits, +1 per wr_pulse, saturates at 2**N. Frame available when cnt==2**N.
//  frame_drop: set when wr_pulse arrives while cnt==2**N and state==IDLE; cleared only by reset.
//  States:
//   IDLE:  if cnt==2**N && fft_ready -> capture base=wr_addr, rd_idx=0, cnt=wr_pulse?1:0, go READ.
//   READ:  buf_en_rd=1, buf_add_rd=base+rd_idx (mod 2**N wrap), rd_idx++ each cycle.
//          rd_idx==2**N-1 issued -> DRAIN.
//   DRAIN: buf_en_rd=0; the last read data is written this cycle -> START.
//   START: fft_start=1 for exactly 1 cycle -> IDLE.
//  Outputs are registered. Capture edge E: first buffer read presented in cycle E+1.
//   fft_we=1 from E+2 through E+1+2**N, contiguous, 2**N writes total.
//   fft_start in cycle E+2+2**N. busy is high from E+1 through that START cycle.
//  Write k (k=0..2**N-1): fft_addr = bitrev_N(k); data from buffer addr (base+k) mod 2**N.
//  Conversion (offset-binary to signed): real = {~s[SPI_WIDTH-1], s[SPI_WIDTH-2:0],
//   (BIT_WIDTH-SPI_WIDTH) zeros}; imag = 0.
//  fft_din is formed combinationally from buf_dout and is valid whenever fft_we=1.
//  wr_pulse in any state increments cnt (post-capture count restarts from 0/1).
//  Writer cannot overtake the reader: reads run 1/cycle, SPI writes are at most 1 per SPI_WIDTH cycles.
//  fft_ready is sampled only in IDLE. Deassertion during READ/DRAIN/START is ignored.
//  cnt==2**N with fft_ready=0: stay IDLE, keep saturating, flag frame_drop on further writes.
// STRUCTURE
//  fft_pkg: typedef enum logic [1:0] {IDLE, READ, DRAIN, START} ld_state_t;
//           function bitrev(idx, N); localparam FRAME_LEN = 2**N.
//  One always_ff for state/counters/registered outputs, one always_comb for next state and fft_din.
//  No sub-module required; bitrev is a package function.
// TESTING
//  Reset held 3 cycles -> all outputs 0, busy=0, no reads issued.
//  512 wr_pulses at wr_addr 0..511 (buffer = idx), fft_ready=1 -> base=0.
//   Expect 512 fft_we cycles; write k: fft_addr=bitrev9(k), real={~k[7],k[6:0],8'h00}.
//   Then exactly one fft_start.
//  Sample values: 0x80 -> fft_din=32'h0000_0000; 0xFF -> 32'h7F00_0000; 0x00 -> 32'h8000_0000.
//  Wrap: capture with wr_addr=0x1F0 -> reads 0x1F0..0x1FF then 0x000..0x1EF; last write addr=bitrev9(511)=511.
//  fft_ready=0 when cnt saturates, 5 more wr_pulses -> frame_drop=1, busy=0.
//   Raise fft_ready -> frame proceeds, frame_drop stays 1.
//  reset asserted at rd_idx=100 -> next cycle IDLE, fft_we=0, no fft_start.
//   Frame restarts only after 512 new wr_pulses.

Source files
------------

// File: rtl/fft_frame_loader_pkg.sv
// fft_frame_loader_pkg: shared state encoding, frame sizing and bit-reversal helper
//    ld_state_t : loader sequencer states
//    bitrev()   : reverses the low n bits of idx (n <= MAX_N)
package fft_frame_loader_pkg;
   localparam int DEF_N     = 9;
   localparam int FRAME_LEN = 2**DEF_N;
   localparam int MAX_N     = 16;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, START} ld_state_t;
   function automatic logic [MAX_N-1:0] bitrev(input logic [MAX_N-1:0] idx, input int n);
      logic [MAX_N-1:0] r;
      r = {<<{idx}};
      return r >> (MAX_N - n);
   endfunction
endpackage

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: moves one buffered SPI frame (oldest sample first) into FFT memory
//    i_sclk        clock, rising edge
//    i_reset       synchronous, active-low reset
//    i_wr_pulse    one buffer write this cycle
//    i_wr_addr     address the next buffer write will use (oldest sample once full)
//    i_fft_ready   FFT core idle, sampled only in IDLE
//    o_buf_en_rd   buffer read enable
//    o_buf_add_rd  buffer read address
//    i_buf_dout    buffer read data, one cycle after the read request
//    o_fft_we      FFT memory write enable
//    o_fft_addr    FFT memory write address (bit-reversed sample index)
//    o_fft_din     {real, imag}, imag always zero
//    o_fft_start   one-cycle pulse after the whole frame is written
//    o_busy        high outside IDLE
//    o_frame_drop  sticky flag: unread samples overwritten before capture
module fft_frame_loader
   import fft_frame_loader_pkg::*;
#(
   parameter int SPI_WIDTH = 8,
   parameter int BIT_WIDTH = 16,
   parameter int N         = DEF_N
) (
   input  logic                   i_sclk,
   input  logic                   i_reset,
   input  logic                   i_wr_pulse,
   input  logic [N-1:0]           i_wr_addr,
   input  logic                   i_fft_ready,
   output logic                   o_buf_en_rd,
   output logic [N-1:0]           o_buf_add_rd,
   input  logic [SPI_WIDTH-1:0]   i_buf_dout,
   output logic                   o_fft_we,
   output logic [N-1:0]           o_fft_addr,
   output logic [2*BIT_WIDTH-1:0] o_fft_din,
   output logic                   o_fft_start,
   output logic                   o_busy,
   output logic                   o_frame_drop
);
   localparam logic [N:0]   CNT_FULL = (N+1)'(2**N);
   localparam logic [N:0]   CNT_ONE  = (N+1)'(1);
   localparam logic [N-1:0] IDX_ONE  = N'(1);

   ld_state_t              r_state, w_state_nxt;
   logic [N:0]             r_cnt;
   logic [N-1:0]           r_rd_idx, r_buf_add_rd, r_fft_addr;
   logic                   r_buf_en_rd, r_fft_we, r_fft_start, r_busy, r_frame_drop;
   logic                   w_full, w_last, w_capture;
   logic [BIT_WIDTH-1:0]   w_real;

   always_comb begin
      w_full      = (r_cnt == CNT_FULL);
      w_last      = &r_rd_idx;
      w_capture   = (r_state == IDLE) && w_full && i_fft_ready;
      w_state_nxt = (r_state == IDLE)  ? (w_capture ? READ : IDLE) :
                    (r_state == READ)  ? (w_last ? DRAIN : READ) :
                    (r_state == DRAIN) ? START : IDLE;
      // offset-binary to two's complement: flip the MSB, left-justify in BIT_WIDTH
      w_real      = BIT_WIDTH'({~i_buf_dout[SPI_WIDTH-1], i_buf_dout[SPI_WIDTH-2:0]}) << (BIT_WIDTH - SPI_WIDTH);
      // gated so the output reads zero whenever no write is in flight
      o_fft_din   = r_fft_we ? {w_real, {BIT_WIDTH{1'b0}}} : '0;
   end

   always_ff @(posedge i_sclk) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_rd_idx     <= '0;
         r_buf_en_rd  <= 1'b0;
         r_buf_add_rd <= '0;
         r_fft_we     <= 1'b0;
         r_fft_addr   <= '0;
         r_fft_start  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_drop <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         // a write landing on the capture edge is the first sample of the next frame
         r_cnt        <= w_capture ? (N+1)'(i_wr_pulse) :
                         (i_wr_pulse && !w_full) ? r_cnt + CNT_ONE : r_cnt;
         r_frame_drop <= r_frame_drop | (i_wr_pulse & w_full & (r_state == IDLE));
         r_rd_idx     <= (r_state == READ && !w_last) ? r_rd_idx + IDX_ONE : '0;
         r_buf_en_rd  <= (w_state_nxt == READ);
         // address wraps naturally modulo the buffer depth
         r_buf_add_rd <= w_capture ? i_wr_addr :
                         (r_state == READ) ? r_buf_add_rd + IDX_ONE : r_buf_add_rd;
         // read data for index k arrives one cycle after its request, so the write trails by one
         r_fft_we     <= (r_state == READ);
         r_fft_addr   <= (r_state == READ) ? N'(bitrev(MAX_N'(r_rd_idx), N)) : '0;
         r_fft_start  <= (r_state == DRAIN);
         r_busy       <= (w_state_nxt != IDLE);
      end
   end

   assign o_buf_en_rd  = r_buf_en_rd;
   assign o_buf_add_rd = r_buf_add_rd;
   assign o_fft_we     = r_fft_we;
   assign o_fft_addr   = r_fft_addr;
   assign o_fft_start  = r_fft_start;
   assign o_busy       = r_busy;
   assign o_frame_drop = r_frame_drop;
endmodule
